// File: rtl/ddr2_addr_gen_pkg.sv
// Shared encodings for the DDR2 address-sequence generator: command codes,
// sequence modes and FSM states.
package ddr2_addr_gen_pkg;

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned MODE_W = 2;

    localparam logic [CMD_W-1:0] CMD_WR = 3'b000;
    localparam logic [CMD_W-1:0] CMD_RD = 3'b001;

    typedef enum logic [MODE_W-1:0] {
        MODE_WR_ONLY    = 2'd0,
        MODE_RD_ONLY    = 2'd1,
        MODE_WR_THEN_RD = 2'd2,
        MODE_INTERLEAVE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/ddr2_addr_incr.sv
// Combinational next-address: column steps by BURST_LEN, with overflow
// rippling column -> row -> bank -> chip-select -> wrap to zero.
module ddr2_addr_incr #(
    parameter int unsigned COL_W     = 10,
    parameter int unsigned ROW_W     = 13,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned CS_W      = 1,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned ADDR_W   = CS_W + BANK_W + ROW_W + COL_W
) (
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out
);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [CS_W-1:0]   cs;

    logic [COL_W:0]  col_sum;
    logic [ROW_W:0]  row_sum;
    logic [BANK_W:0] bank_sum;
    logic [CS_W:0]   cs_sum;
    logic [COL_W-1:0] col_next;

    assign {cs, bank, row, col} = addr_in;

    assign col_sum  = {1'b0, col}  + (COL_W+1)'(BURST_LEN);
    assign row_sum  = {1'b0, row}  + (ROW_W+1)'(col_sum[COL_W]);
    assign bank_sum = {1'b0, bank} + (BANK_W+1)'(row_sum[ROW_W]);
    assign cs_sum   = {1'b0, cs}   + (CS_W+1)'(bank_sum[BANK_W]);

    // A column overflow restarts the new row at column 0.
    assign col_next = col_sum[COL_W] ? '0 : col_sum[COL_W-1:0];

    assign addr_out = {cs_sum[CS_W-1:0], bank_sum[BANK_W-1:0],
                       row_sum[ROW_W-1:0], col_next};

endmodule

// File: rtl/ddr2_addr_gen_param.sv
// Generates write/read command+address streams into a DDR2 address FIFO,
// honouring almost-full back-pressure without skipping or repeating addresses.
module ddr2_addr_gen_param
    import ddr2_addr_gen_pkg::*;
#(
    parameter int unsigned COL_W     = 10,
    parameter int unsigned ROW_W     = 13,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned CS_W      = 1,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned ADDR_W   = CS_W + BANK_W + ROW_W + COL_W
) (
    input  logic                clk0,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [CNT_W-1:0]    num_cmds,
    input  logic                app_af_afull,
    output logic [3+ADDR_W-1:0] app_af_addr,
    output logic                app_af_wren,
    output logic                busy,
    output logic                done
);

    state_e              state, state_nxt;
    mode_e               mode_q, mode_nxt;
    logic [ADDR_W-1:0]   cur_addr, cur_nxt, base_addr, base_nxt, incr_addr;
    logic [CNT_W-1:0]    cnt, cnt_nxt, num_q, num_nxt;
    logic [3+ADDR_W-1:0] af_addr_nxt;
    logic                wren_nxt, busy_nxt, done_nxt, last;

    ddr2_addr_incr #(
        .COL_W     (COL_W),
        .ROW_W     (ROW_W),
        .BANK_W    (BANK_W),
        .CS_W      (CS_W),
        .BURST_LEN (BURST_LEN)
    ) u_incr (
        .addr_in  (cur_addr),
        .addr_out (incr_addr)
    );

    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk0) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            mode_q      <= MODE_WR_ONLY;
            cur_addr    <= '0;
            base_addr   <= '0;
            cnt         <= '0;
            num_q       <= '0;
            app_af_addr <= '0;
            app_af_wren <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mode_q      <= mode_nxt;
            cur_addr    <= cur_nxt;
            base_addr   <= base_nxt;
            cnt         <= cnt_nxt;
            num_q       <= num_nxt;
            app_af_addr <= af_addr_nxt;
            app_af_wren <= wren_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state and next-output decode; an issue only happens when the FIFO has room.
    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        cur_nxt     = cur_addr;
        base_nxt    = base_addr;
        cnt_nxt     = cnt;
        num_nxt     = num_q;
        af_addr_nxt = '0;
        wren_nxt    = 1'b0;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    mode_nxt = mode_e'(mode);
                    cur_nxt  = start_addr;
                    base_nxt = start_addr;
                    cnt_nxt  = num_cmds;
                    num_nxt  = num_cmds;
                    busy_nxt = 1'b1;
                    if (num_cmds == '0)                    state_nxt = ST_DONE;
                    else if (mode_e'(mode) == MODE_RD_ONLY) state_nxt = ST_ISSUE_RD;
                    else                                    state_nxt = ST_ISSUE_WR;
                end
            end
            ST_ISSUE_WR: begin
                if (!app_af_afull) begin
                    wren_nxt    = 1'b1;
                    af_addr_nxt = {CMD_WR, cur_addr};
                    if (mode_q == MODE_INTERLEAVE) begin
                        state_nxt = ST_ISSUE_RD;
                    end else begin
                        cur_nxt = incr_addr;
                        cnt_nxt = cnt - CNT_W'(1);
                        if (last) begin
                            if (mode_q == MODE_WR_THEN_RD) begin
                                cur_nxt   = base_addr;
                                cnt_nxt   = num_q;
                                state_nxt = ST_ISSUE_RD;
                            end else begin
                                state_nxt = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_ISSUE_RD: begin
                if (!app_af_afull) begin
                    wren_nxt    = 1'b1;
                    af_addr_nxt = {CMD_RD, cur_addr};
                    cur_nxt     = incr_addr;
                    cnt_nxt     = cnt - CNT_W'(1);
                    if (last)                             state_nxt = ST_DONE;
                    else if (mode_q == MODE_INTERLEAVE)   state_nxt = ST_ISSUE_WR;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/ddr2_addr_gen_param.md
DDR2_ADDR_GEN_PARAM -- requirements
Module: ddr2_addr_gen_param

Interface
REQ-001 SHALL have parameter COL_W, default 10, column address bits.
REQ-002 SHALL have parameter ROW_W, default 13, row address bits.
REQ-003 SHALL have parameter BANK_W, default 2, bank address bits.
REQ-004 SHALL have parameter CS_W, default 1, chip-select bits.
REQ-005 SHALL have parameter BURST_LEN, default 4 (legal values 4 or 8), column step per command.
REQ-006 SHALL have parameter CNT_W, default 16, command-count width.
REQ-007 SHALL define ADDR_W = CS_W+BANK_W+ROW_W+COL_W, with address packing {cs, bank, row, col}.
REQ-008 SHALL have port clk0, input, 1, the single clock; one clock, and reset is synchronous and active-low.
REQ-009 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-010 SHALL have port start, input, 1, one-cycle request to begin a sequence.
REQ-011 SHALL have port mode, input, 2, sequence mode, sampled with start.
REQ-012 SHALL have port start_addr, input, ADDR_W, first address, sampled with start.
REQ-013 SHALL have port num_cmds, input, CNT_W, commands per phase (pairs in mode 3), sampled with start.
REQ-014 SHALL have port app_af_afull, input, 1, address-FIFO almost-full.
REQ-015 SHALL have port app_af_addr, output, 3+ADDR_W, {cmd[2:0], addr}.
REQ-016 SHALL have port app_af_wren, output, 1, address-FIFO write enable.
REQ-017 SHALL have port busy, output, 1, high while a sequence is active.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-019 SHALL use cmd codes WR=3'b000 and RD=3'b001.
REQ-020 SHALL support modes: 0 write-only; 1 read-only; 2 all writes, then all reads over the same addresses; 3 interleaved W(a), R(a), W(a+1), R(a+1) and so on.
REQ-021 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, DONE.
- IDLE->ISSUE_WR on start for modes 0, 2 and 3.
- IDLE->ISSUE_RD on start for mode 1.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL register outputs: if start is sampled at edge k, the first app_af_wren=1 appears after edge k+1.
REQ-024 SHALL issue one command per cycle in which the FSM is in an issue state and app_af_afull=0 at that edge, with no gap cycles.
REQ-025 SHALL, while app_af_afull=1, drive app_af_wren=0 and hold the current address and counters; on resume it SHALL issue the same pending address with no skip and no duplicate.
REQ-026 SHALL drive app_af_addr to all-zero whenever app_af_wren=0.
REQ-027 SHALL compute the next address as col+BURST_LEN, with this carry chain:
- column overflow wraps to 0 and increments row;
- row overflow wraps and increments bank;
- bank overflow wraps and increments cs;
- full overflow wraps to address 0.
REQ-028 SHALL, in mode 2, reload the captured start_addr and enter ISSUE_RD directly after the last write, with no idle cycle.
REQ-029 SHALL, in mode 3, advance the address only after each RD; W and R of a pair SHALL carry the same address.
REQ-030 SHALL pulse done for exactly one cycle, in the cycle after the final app_af_wren, then return to IDLE; busy SHALL fall in the same cycle as done.
REQ-031 SHALL treat num_cmds=0 as issuing no command, with done pulsed one cycle after start is sampled.
REQ-032 SHALL make busy=1 from the cycle after start is sampled through the last command cycle.

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, force app_af_wren=0, app_af_addr=0, busy=0, done=0, state IDLE, and counters/address to 0.
REQ-034 SHALL abort any active sequence on mid-operation reset, with no done pulse and no further commands.
REQ-035 SHALL accept start on the first edge after rst_n returns high.

Structure
REQ-036 SHALL place the cmd codes, mode encodings and state encoding in shared package ddr2_addr_gen_pkg.
REQ-037 SHALL implement the carry-chain increment in sub-module ddr2_addr_incr, a parametrised combinational block instantiated once.

Verification
REQ-038 SHALL cover mode 0, start_addr=0, num_cmds=4: wren high for 4 consecutive cycles, addr col 0, 4, 8, 12, cmd 000, done in the next cycle.
REQ-039 SHALL cover mode 1, start_addr={cs0, bank0, row5, col1020}, num_cmds=2: cmd 001 at col 1020/row 5, then col 0/row 6.
REQ-040 SHALL cover mode 0, num_cmds=6, with app_af_afull high for 3 cycles after the 2nd command: 3 cycles with wren=0, then col 8, 12, 16, 20; exactly 6 commands total.
REQ-041 SHALL cover mode 2, num_cmds=3, start_addr=0: WR col 0, 4, 8, then RD col 0, 4, 8 in 6 consecutive cycles, then one done pulse.
REQ-042 SHALL cover mode 3, num_cmds=2: WR0, RD0, WR4, RD4; then rst_n=0 after the 2nd command of a new run gives wren=0 and busy=0 next cycle, and no done.
REQ-043 SHALL cover num_cmds=0: no wren, done pulses one cycle after start; a start asserted while busy is ignored.
